// File: rtl/bcd_time_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_time_counter_if
// Bundles the user controls and the displayed time of the BCD clock.
//   set_mode  : 1 = time-set mode, 0 = run mode
//   inc_min   : one-cycle minute-increment request (set mode only)
//   inc_hour  : one-cycle hour-increment request (set mode only)
//   h_tens .. s_ones : BCD digits of HH:MM:SS, one per seven-segment decoder
//   tick_1hz  : one-cycle pulse on every second boundary in run mode
// master = the side driving the controls, slave = the counter itself.
// ---------------------------------------------------------------------------
interface bcd_time_counter_if;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hour;
    logic [3:0] h_tens;
    logic [3:0] h_ones;
    logic [3:0] m_tens;
    logic [3:0] m_ones;
    logic [3:0] s_tens;
    logic [3:0] s_ones;
    logic       tick_1hz;

    modport master (
        output set_mode, inc_min, inc_hour,
        input  h_tens, h_ones, m_tens, m_ones, s_tens, s_ones, tick_1hz
    );

    modport slave (
        input  set_mode, inc_min, inc_hour,
        output h_tens, h_ones, m_tens, m_ones, s_tens, s_ones, tick_1hz
    );
endinterface

// File: rtl/bcd_time_counter.sv
// ---------------------------------------------------------------------------
// bcd_time_counter
// 24-hour HH:MM:SS clock kept directly in BCD, driven by a prescaler that
// divides clk down to one tick per second.
//   CLK_HZ : clk cycles per second (>= 2)
//   clk    : single clock, rising edge
//   rst_n  : asynchronous assert, active-low reset (time 00:00:00)
//   bus    : bcd_time_counter_if.slave -- set_mode / inc_min / inc_hour in,
//            six BCD digits and tick_1hz out (all outputs registered)
// Set mode freezes the prescaler and the seconds at zero and lets the user
// step minutes and hours independently (no carry between them).
// ---------------------------------------------------------------------------
module bcd_time_counter #(
    parameter int CLK_HZ = 100000000
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_time_counter_if.slave   bus
);
    localparam int              PW         = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);

    // Each field is a packed BCD pair {tens, ones}.
    logic [PW-1:0] prescaler_reg, prescaler_next;
    logic [7:0]    hours_reg,     hours_next;
    logic [7:0]    minutes_reg,   minutes_next;
    logic [7:0]    seconds_reg,   seconds_next;
    logic          tick_reg,      tick_next;
    logic          second_boundary;

    // BCD 00..59 increment with wrap to 00.
    function automatic logic [7:0] inc_mod60(input logic [7:0] bcd);
        logic [7:0] r;
        r = bcd;
        if (bcd[3:0] >= 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (bcd[7:4] >= 4'd5) ? 4'd0 : bcd[7:4] + 4'd1;
        end else begin
            r[3:0] = bcd[3:0] + 4'd1;
        end
        return r;
    endfunction

    // BCD 00..23 increment with wrap to 00.
    function automatic logic [7:0] inc_mod24(input logic [7:0] bcd);
        logic [7:0] r;
        r = bcd;
        if (bcd[7:4] >= 4'd2 && bcd[3:0] >= 4'd3) begin
            r = 8'h00;
        end else if (bcd[3:0] >= 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = bcd[7:4] + 4'd1;
        end else begin
            r[3:0] = bcd[3:0] + 4'd1;
        end
        return r;
    endfunction

    always_comb begin
        prescaler_next  = prescaler_reg;
        hours_next      = hours_reg;
        minutes_next    = minutes_reg;
        seconds_next    = seconds_reg;
        tick_next       = 1'b0;
        second_boundary = (prescaler_reg == PRESC_LAST);

        if (bus.set_mode) begin
            // Set mode takes priority over a coincident second boundary.
            prescaler_next = '0;
            seconds_next   = 8'h00;
            if (bus.inc_min) begin
                minutes_next = inc_mod60(minutes_reg);
            end
            if (bus.inc_hour) begin
                hours_next = inc_mod24(hours_reg);
            end
        end else begin
            prescaler_next = second_boundary ? '0 : prescaler_reg + PW'(1);
            if (second_boundary) begin
                tick_next    = 1'b1;
                seconds_next = inc_mod60(seconds_reg);
                // Full ripple of carries happens in the same update.
                if (seconds_reg == 8'h59) begin
                    minutes_next = inc_mod60(minutes_reg);
                    if (minutes_reg == 8'h59) begin
                        hours_next = inc_mod24(hours_reg);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_reg <= '0;
            hours_reg     <= 8'h00;
            minutes_reg   <= 8'h00;
            seconds_reg   <= 8'h00;
            tick_reg      <= 1'b0;
        end else begin
            prescaler_reg <= prescaler_next;
            hours_reg     <= hours_next;
            minutes_reg   <= minutes_next;
            seconds_reg   <= seconds_next;
            tick_reg      <= tick_next;
        end
    end

    assign bus.h_tens   = hours_reg[7:4];
    assign bus.h_ones   = hours_reg[3:0];
    assign bus.m_tens   = minutes_reg[7:4];
    assign bus.m_ones   = minutes_reg[3:0];
    assign bus.s_tens   = seconds_reg[7:4];
    assign bus.s_ones   = seconds_reg[3:0];
    assign bus.tick_1hz = tick_reg;

endmodule

// File: tb/tb_bcd_time_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_time_counter
// Self-checking bench for bcd_time_counter with CLK_HZ = 4. The reference
// model keeps the time as plain seconds-of-day and counts run-mode cycles
// inside the current second; directed scenarios are followed by a random
// mix of set/run activity and asynchronous resets.
// ---------------------------------------------------------------------------
module tb_bcd_time_counter;
    localparam int CLK_HZ = 4;

    logic clk = 1'b0;
    logic rst_n;

    bcd_time_counter_if bus();

    bcd_time_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   t_model      = 0;   // seconds since midnight
    int   run_cnt      = 0;   // run-mode cycles elapsed in current second
    logic tick_model   = 1'b0;
    int   tick_seen    = 0;

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] time_bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {8'h00, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [31:0] dut_time();
        return {8'h00, bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones,
                bus.s_tens, bus.s_ones};
    endfunction

    task automatic model_reset();
        t_model    = 0;
        run_cnt    = 0;
        tick_model = 1'b0;
    endtask

    task automatic model_step(input logic sm, input logic im, input logic ih);
        int h, m;
        if (sm) begin
            h = t_model / 3600;
            m = (t_model / 60) % 60;
            if (im) m = (m + 1) % 60;
            if (ih) h = (h + 1) % 24;
            t_model    = h * 3600 + m * 60;
            run_cnt    = 0;
            tick_model = 1'b0;
        end else begin
            run_cnt++;
            if (run_cnt == CLK_HZ) begin
                run_cnt    = 0;
                t_model    = (t_model + 1) % 86400;
                tick_model = 1'b1;
            end else begin
                tick_model = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, clock, advance model, compare.
    task automatic cycle(input logic sm, input logic im, input logic ih);
        bus.set_mode = sm;
        bus.inc_min  = im;
        bus.inc_hour = ih;
        @(posedge clk);
        model_step(sm, im, ih);
        #1;
        if (bus.tick_1hz) tick_seen++;
        check_eq("time", dut_time(), time_bcd(t_model));
        check_eq("tick", {31'b0, bus.tick_1hz}, {31'b0, tick_model});
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Enter set mode and step hours/minutes to the target, pulsing both
    // together whenever both still need to advance.
    task automatic set_hm(input int h, input int m);
        int nh, nm, n;
        cycle(1'b1, 1'b0, 1'b0);
        nh = (h - t_model / 3600 + 24) % 24;
        nm = (m - (t_model / 60) % 60 + 60) % 60;
        n  = (nh > nm) ? nh : nm;
        for (int i = 0; i < n; i++) cycle(1'b1, i < nm, i < nh);
    endtask

    // Called just after a rising edge; asserts reset between edges.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_eq({tag, "_digits"}, dut_time(), 32'h0);
        check_eq({tag, "_tick"}, {31'b0, bus.tick_1hz}, 32'h0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int t0;
        logic sm;
        rst_n        = 1'b1;
        bus.set_mode = 1'b0;
        bus.inc_min  = 1'b0;
        bus.inc_hour = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check_eq("reset_digits", dut_time(), 32'h0);
        check_eq("reset_tick", {31'b0, bus.tick_1hz}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        $display("[TB] reset released, time 00:00:00");

        // First second after reset, then 10 seconds
        t0 = tick_seen;
        run_cycles(4);
        check_eq("first_tick_count", tick_seen - t0, 1);
        check_eq("first_s_ones", {28'b0, bus.s_ones}, 32'd1);
        run_cycles(36);
        check_eq("ten_s_tens", {28'b0, bus.s_tens}, 32'd1);
        check_eq("ten_s_ones", {28'b0, bus.s_ones}, 32'd0);
        $display("[TB] run 40 cycles -> %0d%0d s", bus.s_tens, bus.s_ones);

        // Minute-to-hour carry
        set_hm(0, 59);
        run_cycles(59 * CLK_HZ);
        check_eq("preload_005959", dut_time(), 32'h005959);
        run_cycles(CLK_HZ);
        check_eq("carry_010000", dut_time(), 32'h010000);
        $display("[TB] 00:59:59 -> %h", dut_time());

        // Midnight rollover
        set_hm(23, 59);
        run_cycles(59 * CLK_HZ);
        check_eq("preload_235959", dut_time(), 32'h235959);
        run_cycles(CLK_HZ);
        check_eq("midnight_000000", dut_time(), 32'h000000);
        $display("[TB] 23:59:59 -> %h", dut_time());

        // Set-mode behaviour
        set_hm(12, 34);
        run_cycles(27 * CLK_HZ);
        check_eq("preload_123427", dut_time(), 32'h123427);
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("set_clears_sec", dut_time(), 32'h123400);
        set_hm(12, 59);
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("min_wrap_no_carry", dut_time(), 32'h120000);
        set_hm(23, 0);
        cycle(1'b1, 1'b0, 1'b1);
        check_eq("hour_wrap", dut_time(), 32'h000000);
        set_hm(5, 7);
        cycle(1'b1, 1'b1, 1'b1);
        check_eq("both_inc", dut_time(), 32'h060800);
        $display("[TB] set-mode increments done, time %h", dut_time());

        // set_mode rising on the second boundary wins; full first second after
        run_cycles(CLK_HZ - 1);
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("race_no_tick", {31'b0, bus.tick_1hz}, 32'h0);
        check_eq("race_no_inc", dut_time(), 32'h060800);
        n = 0;
        for (int i = 0; i < 3 * CLK_HZ; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
            if (bus.tick_1hz) break;
        end
        check_eq("first_tick_latency", n, CLK_HZ);
        $display("[TB] boundary race: first tick after %0d cycles", n);

        // Asynchronous reset at 14:22:37
        set_hm(14, 22);
        run_cycles(37 * CLK_HZ);
        check_eq("preload_142237", dut_time(), 32'h142237);
        async_reset("async_rst");
        t0 = tick_seen;
        run_cycles(CLK_HZ);
        check_eq("post_reset_tick", tick_seen - t0, 1);
        $display("[TB] async reset at 14:22:37 -> %h", dut_time());

        // Random set/run mix with occasional asynchronous resets
        sm = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) sm = ~sm;
            cycle(sm, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) async_reset("rand_rst");
        end
        $display("[TB] random phase done, time %h", dut_time());

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
